seg_capture: RTL and testbench
==============================

// Module: seg_capture
// PURPOSE
//  Reader side of the multiplexed seven-segment display bus: samples the active-low
//  segment lines and active-low digit enables the display driver produces.
//  Decodes each stable pattern back to its 4-bit hex value, once per digit.
//  Used in-system as a loopback self-check of the display path.
//  Used in simulation as a scoreboard monitor for display-driver benches.
// PARAMETERS
//  NUM_DIGITS     2  number of multiplexed digits (anode lines), 1..8
//  STABLE_CYCLES  4  synchronized samples a pattern must hold before capture, >=2
//  (derived) CNT_W = $clog2(STABLE_CYCLES+1), width of the stability counter
// PORTS
//  clk          in   1             system clock
//  reset        in   1             asynchronous, active-high reset
//  seg          in   7             segment bus {g,f,e,d,c,b,a}, active-low, async to clk
//  an           in   NUM_DIGITS    digit enables, active-low, async to clk
//  digit_out    out  4*NUM_DIGITS  decoded hex per digit; digit k at [4k+3:4k]
//  digit_valid  out  NUM_DIGITS    1 = digit k holds a decoded value; 0 = blank or never seen
//  update       out  NUM_DIGITS    one-hot, 1-cycle pulse: digit k captured (value or blank)
//  bad_pattern  out  1             1-cycle pulse: stable pattern not in decode table
//  anode_err    out  1             1-cycle pulse: >1 anode low simultaneously
// BEHAVIOUR
//  Clock and reset
//   - Single clock domain. reset is asynchronous and active-high.
//   - Reset values:
//     - digit_out, digit_valid, update, bad_pattern, anode_err = 0.
//     - FSM state = IDLE; counter = 0.
//     - Sync, prev regs: seg = 7'h7F, an = all 1s (idle bus, no false capture).
//   - Reset asserted mid-operation: everything clears immediately. No capture completes.
//  Input path
//   - seg and an pass through a 2-flop synchronizer, giving s_seg and s_an.
//   - prev holds the {s_seg, s_an} value from the previous cycle.
//   - chg = ({s_seg, s_an} != prev).
//  Decode table (seg hex -> value)
//   - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
//   - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
//   - 7F = blank. Any other code is bad.
//  FSM states and transitions
//   - IDLE: zero anodes low, or more than one anode low.
//   - TRACK: exactly one anode (k) low; stability counter running.
//   - HELD: the current pattern has already been captured.
//   - Any state, chg=1: counter = 1.
//     - Next state TRACK if exactly one anode is low, otherwise IDLE.
//     - Entering IDLE because >1 anode is low: anode_err pulses once per entry.
//   - TRACK, chg=0: counter increments.
//     - When counter reaches STABLE_CYCLES, capture occurs and next state is HELD.
//   - HELD, chg=0: no action. A pattern is never re-captured while it is held.
//  Capture (digit k, registered; outputs visible the following cycle)
//   - Table hit: digit_out[k] = value, digit_valid[k] = 1, update[k] pulses.
//   - Blank (7F): digit_valid[k] = 0, digit_out[k] unchanged, update[k] pulses.
//   - Miss: bad_pattern pulses; digit_out[k] and digit_valid[k] unchanged.
//  Timing and scope
//   - Latency: input held constant from the first clk edge that samples it.
//     update is high exactly STABLE_CYCLES+2 cycles after that edge.
//   - Glitches shorter than STABLE_CYCLES synchronized samples are ignored entirely.
//   - Only digit k is ever written on its capture. Other digits hold their values.
// TESTING
//  1. Reset, then an=2'b10, seg=7'h24 held 10 cycles.
//     -> update=2'b01 exactly once, at cycle STABLE_CYCLES+2.
//     -> digit_out[3:0]=2, digit_valid=2'b01.
//  2. Alternate an=10/seg=30 and an=01/seg=0E, 8 cycles each, for 4 rounds.
//     -> digit_out=8'hF3, digit_valid=11.
//     -> update pulses once per dwell, alternating 01/10.
//  3. an=10, seg=24 for 2 cycles, then seg=30 for 8 cycles.
//     -> no capture of 2; digit_out[3:0]=3; exactly 1 update pulse.
//  4. After test 1, hold an=10, seg=7'h55 for 8 cycles.
//     -> bad_pattern one pulse; digit_out and digit_valid unchanged.
//     -> Then seg=7F -> digit_valid[0]=0, update pulse.
//  5. an=00 with any seg for 8 cycles.
//     -> anode_err one pulse; no update; digits unchanged.
//  6. Assert reset mid-TRACK (cycle 3 of dwell), release, keep inputs.
//     -> all outputs 0 during reset.
//     -> Fresh capture STABLE_CYCLES+2 cycles after release.
//  Sweep all 16 table codes on each digit; every code must decode to its value.

Source files
------------

// File: rtl/seg_capture_if.sv
//------------------------------------------------------------------------------
// Module   : seg_capture_if
// Purpose  : Bundles the multiplexed seven-segment display bus together with
//            the decoded results produced by the segment capture block.
// Ports    : seg          7-bit segment bus {g,f,e,d,c,b,a}, active-low
//            an           NUM_DIGITS digit enables, active-low
//            digit_out    4*NUM_DIGITS decoded hex values, digit k at [4k+3:4k]
//            digit_valid  per-digit "holds a decoded value" flags
//            update       one-hot single-cycle capture strobe
//            bad_pattern  single-cycle strobe, stable pattern not decodable
//            anode_err    single-cycle strobe, more than one anode low
//            master = display-driver side, slave = capture side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seg_capture_if #(
  parameter int NUM_DIGITS = 2
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [4*NUM_DIGITS-1:0] digit_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   update;
  logic                    bad_pattern;
  logic                    anode_err;

  // Display driver (or a bench standing in for it): drives the bus,
  // observes the decoded results.
  modport master (
    output seg,
    output an,
    input  digit_out,
    input  digit_valid,
    input  update,
    input  bad_pattern,
    input  anode_err
  );

  // Capture block: samples the bus, reports decoded results.
  modport slave (
    input  seg,
    input  an,
    output digit_out,
    output digit_valid,
    output update,
    output bad_pattern,
    output anode_err
  );
endinterface

`default_nettype wire

// File: rtl/seg_capture.sv
//------------------------------------------------------------------------------
// Module   : seg_capture
// Purpose  : Reader side of a multiplexed seven-segment display bus. Samples
//            the active-low segment lines and digit enables, waits for a
//            pattern to be stable, then decodes it back to a 4-bit hex value
//            exactly once per stable dwell on a digit.
// Ports    : clk    system clock
//            reset  asynchronous, active-high reset
//            bus    seg_capture_if.slave (seg/an in, decoded results out)
// Params   : NUM_DIGITS     number of multiplexed digits, 1..8
//            STABLE_CYCLES  synchronized samples a pattern must hold, >= 2
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_capture #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  seg_capture_if.slave  bus
);

  //----------------------------------------------------------------------------
  // Constants
  //----------------------------------------------------------------------------
  localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);

  localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  localparam logic [6:0] c_seg_blank = 7'h7F;

  // Tracker states
  localparam logic [1:0] c_st_idle  = 2'd0;  // no single anode selected
  localparam logic [1:0] c_st_track = 2'd1;  // single anode, counting stability
  localparam logic [1:0] c_st_held  = 2'd2;  // current pattern already captured

  //----------------------------------------------------------------------------
  // Helper functions
  //----------------------------------------------------------------------------
  // Number of active-low anodes asserted.
  function automatic logic [3:0] f_low_cnt(input logic [NUM_DIGITS-1:0] a);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!a[i]) begin
        n = n + 4'd1;
      end
    end
    return n;
  endfunction

  // Segment code to hex value; bit 4 flags a table hit.
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  //----------------------------------------------------------------------------
  // Registers
  //----------------------------------------------------------------------------
  // Two-flop synchronizer. seg/an are a multi-bit bus synchronized bitwise;
  // any skew between bits only shows up as short-lived patterns, which the
  // stability counter rejects.
  logic [6:0]              r_seg_meta;
  logic [6:0]              r_s_seg;
  logic [NUM_DIGITS-1:0]   r_an_meta;
  logic [NUM_DIGITS-1:0]   r_s_an;

  // Previous synchronized sample, for change detection.
  logic [6:0]              r_prev_seg;
  logic [NUM_DIGITS-1:0]   r_prev_an;

  logic [1:0]              r_state;
  logic [c_cnt_w-1:0]      r_cnt;

  logic [4*NUM_DIGITS-1:0] r_digit_out;
  logic [NUM_DIGITS-1:0]   r_digit_valid;
  logic [NUM_DIGITS-1:0]   r_update;
  logic                    r_bad_pattern;
  logic                    r_anode_err;

  //----------------------------------------------------------------------------
  // Combinational decode of the current synchronized sample
  //----------------------------------------------------------------------------
  logic                    w_chg;
  logic [3:0]              w_low_now;
  logic [3:0]              w_low_prev;
  logic                    w_single;
  logic                    w_multi;
  logic                    w_multi_prev;
  logic                    w_capture;
  logic [4:0]              w_dec;
  logic                    w_hit;
  logic                    w_blank;

  always_comb begin
    w_chg        = ({r_s_seg, r_s_an} != {r_prev_seg, r_prev_an});
    w_low_now    = f_low_cnt(r_s_an);
    w_low_prev   = f_low_cnt(r_prev_an);
    w_single     = (w_low_now == 4'd1);
    w_multi      = (w_low_now > 4'd1);
    w_multi_prev = (w_low_prev > 4'd1);
    // Capture fires on the sample after the counter has reached the
    // threshold with no change; the state then moves to HELD so the same
    // pattern cannot be captured twice.
    w_capture    = (r_state == c_st_track) && !w_chg && (r_cnt == c_stable);
    w_dec        = f_decode(r_s_seg);
    w_hit        = w_dec[4];
    w_blank      = (r_s_seg == c_seg_blank);
  end

  //----------------------------------------------------------------------------
  // Sequential logic
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Sync and history regs reset to the idle bus so a quiet bus after
      // reset never looks like a change.
      r_seg_meta    <= c_seg_blank;
      r_s_seg       <= c_seg_blank;
      r_an_meta     <= '1;
      r_s_an        <= '1;
      r_prev_seg    <= c_seg_blank;
      r_prev_an     <= '1;
      r_state       <= c_st_idle;
      r_cnt         <= '0;
      r_digit_out   <= '0;
      r_digit_valid <= '0;
      r_update      <= '0;
      r_bad_pattern <= 1'b0;
      r_anode_err   <= 1'b0;
    end else begin
      r_seg_meta    <= bus.seg;
      r_s_seg       <= r_seg_meta;
      r_an_meta     <= bus.an;
      r_s_an        <= r_an_meta;
      r_prev_seg    <= r_s_seg;
      r_prev_an     <= r_s_an;

      // Strobes default low; they are single-cycle by construction.
      r_update      <= '0;
      r_bad_pattern <= 1'b0;
      r_anode_err   <= 1'b0;

      if (w_chg) begin
        // Any change restarts stability counting from the new sample.
        r_cnt   <= c_one;
        r_state <= w_single ? c_st_track : c_st_idle;
        // Report a multi-anode fault only on the transition into it, not
        // again for segment changes while the fault persists.
        if (w_multi && !w_multi_prev) begin
          r_anode_err <= 1'b1;
        end
      end else begin
        case (r_state)
          c_st_track: begin
            if (w_capture) begin
              r_state <= c_st_held;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          default: begin
            // IDLE and HELD wait for the next change.
          end
        endcase
      end

      if (w_capture) begin
        if (!w_hit && !w_blank) begin
          r_bad_pattern <= 1'b1;
        end
        // Exactly one anode is low while tracking, so only that digit is
        // written; every other digit keeps its value.
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (!r_s_an[k]) begin
            if (w_hit) begin
              r_digit_out[4*k +: 4] <= w_dec[3:0];
              r_digit_valid[k]      <= 1'b1;
              r_update[k]           <= 1'b1;
            end else if (w_blank) begin
              r_digit_valid[k]      <= 1'b0;
              r_update[k]           <= 1'b1;
            end
          end
        end
      end
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign bus.digit_out   = r_digit_out;
  assign bus.digit_valid = r_digit_valid;
  assign bus.update      = r_update;
  assign bus.bad_pattern = r_bad_pattern;
  assign bus.anode_err   = r_anode_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_seg_capture
// Purpose  : Self-checking bench for seg_capture. A reference model works on
//            the raw history of bus samples: a pattern is captured on the
//            cycle whose sample two edges back completes a run of exactly
//            STABLE_CYCLES+1 identical samples with a single anode low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_capture;

  localparam int ND = 2;
  localparam int S  = 4;

  typedef logic [6+ND:0] samp_t;  // {seg, an}

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seg_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg_capture #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(S)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Decode table, index = hex value.
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  samp_t          hist[$];
  logic [3:0]     m_dig [ND];
  logic [ND-1:0]  m_valid;

  // Bookkeeping
  int             ntests = 0;
  int             nfail  = 0;
  int             cyc, upd_cnt, upd_last, bad_cnt, aerr_cnt;
  logic [ND-1:0]  last_upd;

  function automatic int lookup(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  function automatic int nlow(input logic [ND-1:0] a);
    int n = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hist_reset();
    hist.delete();
    repeat (S + 4) hist.push_back({7'h7F, {ND{1'b1}}});
  endtask

  task automatic model_clear();
    for (int k = 0; k < ND; k++) m_dig[k] = 4'h0;
    m_valid = '0;
    hist_reset();
  endtask

  task automatic clr_tally();
    cyc = 0; upd_cnt = 0; upd_last = -1; bad_cnt = 0; aerr_cnt = 0; last_upd = '0;
  endtask

  // One clock: record sample, advance model, compare all outputs.
  task automatic step();
    samp_t                cur, pre;
    int                   n, code, k;
    bit                   run_ok;
    logic [ND-1:0]        e_upd;
    logic                 e_bad, e_aerr;
    logic [4*ND-1:0]      e_do;
    @(posedge clk);
    hist.push_back({bus.seg, bus.an});
    if (hist.size() > S + 8) void'(hist.pop_front());
    n   = hist.size();
    cur = hist[n-3];
    pre = hist[n-4];
    run_ok = 1'b1;
    for (int j = 1; j <= S; j++) if (hist[n-3-j] !== cur) run_ok = 1'b0;
    if (hist[n-4-S] === cur) run_ok = 1'b0;
    e_upd = '0; e_bad = 1'b0; e_aerr = 1'b0;
    if (run_ok && nlow(cur[ND-1:0]) == 1) begin
      k = 0;
      for (int i = 0; i < ND; i++) if (!cur[i]) k = i;
      code = lookup(cur[6+ND:ND]);
      if (code >= 0 && code < 16) begin
        m_dig[k] = code[3:0]; m_valid[k] = 1'b1; e_upd[k] = 1'b1;
      end else if (code == 16) begin
        m_valid[k] = 1'b0; e_upd[k] = 1'b1;
      end else begin
        e_bad = 1'b1;
      end
    end
    if (cur !== pre && nlow(cur[ND-1:0]) > 1 && nlow(pre[ND-1:0]) <= 1) e_aerr = 1'b1;
    for (int i = 0; i < ND; i++) e_do[4*i +: 4] = m_dig[i];
    #1;
    cyc++;
    chk("update",      32'(bus.update),      32'(e_upd));
    chk("bad_pattern", 32'(bus.bad_pattern), 32'(e_bad));
    chk("anode_err",   32'(bus.anode_err),   32'(e_aerr));
    chk("digit_out",   32'(bus.digit_out),   32'(e_do));
    chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    if (bus.update != '0) begin
      upd_cnt++; upd_last = cyc; last_upd = bus.update;
    end
    if (bus.bad_pattern) bad_cnt++;
    if (bus.anode_err)   aerr_cnt++;
  endtask

  task automatic dwell(input logic [6:0] s, input logic [ND-1:0] a, input int n);
    bus.seg = s;
    bus.an  = a;
    repeat (n) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_digit_out"},   32'(bus.digit_out),   32'h0);
    chk({tag, "_digit_valid"}, 32'(bus.digit_valid), 32'h0);
    chk({tag, "_update"},      32'(bus.update),      32'h0);
    chk({tag, "_bad"},         32'(bus.bad_pattern), 32'h0);
    chk({tag, "_aerr"},        32'(bus.anode_err),   32'h0);
  endtask

  // Assert reset away from the clock edge, check outputs clear, release.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_zero({tag, "_imm"});
    repeat (2) @(posedge clk);
    #1;
    chk_zero({tag, "_hold"});
    model_clear();
    reset = 1'b0;
  endtask

  initial begin
    bus.seg = 7'h7F;
    bus.an  = '1;
    model_clear();
    clr_tally();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    reset = 1'b0;

    // Test 1: digit 0 shows 2; one update exactly S+2 edges after first sample
    clr_tally();
    dwell(7'h24, 2'b10, 10);
    chk("t1_upd_cnt",  32'(upd_cnt),  32'd1);
    chk("t1_upd_cyc",  32'(upd_last), 32'(S + 3));
    chk("t1_upd_mask", 32'(last_upd), 32'b01);
    chk("t1_digit0",   32'(bus.digit_out[3:0]), 32'h2);
    chk("t1_valid",    32'(bus.digit_valid),    32'b01);

    // Test 4: undecodable pattern, then blank
    clr_tally();
    dwell(7'h55, 2'b10, 8);
    chk("t4_bad_cnt",  32'(bad_cnt), 32'd1);
    chk("t4_upd_cnt",  32'(upd_cnt), 32'd0);
    chk("t4_dout",     32'(bus.digit_out),   32'h02);
    chk("t4_valid",    32'(bus.digit_valid), 32'b01);
    clr_tally();
    dwell(7'h7F, 2'b10, 8);
    chk("t4b_upd_cnt", 32'(upd_cnt), 32'd1);
    chk("t4b_valid",   32'(bus.digit_valid), 32'b00);
    chk("t4b_dout",    32'(bus.digit_out),   32'h02);

    // Test 2: alternate digits
    clr_tally();
    for (int r = 0; r < 4; r++) begin
      dwell(7'h30, 2'b10, 8);
      chk("t2_mask0", 32'(last_upd), 32'b01);
      dwell(7'h0E, 2'b01, 8);
      chk("t2_mask1", 32'(last_upd), 32'b10);
    end
    chk("t2_upd_cnt", 32'(upd_cnt), 32'd8);
    chk("t2_dout",    32'(bus.digit_out),   32'hF3);
    chk("t2_valid",   32'(bus.digit_valid), 32'b11);

    // Test 3: short glitch of 2 ignored
    clr_tally();
    dwell(7'h24, 2'b10, 2);
    dwell(7'h30, 2'b10, 8);
    chk("t3_upd_cnt", 32'(upd_cnt), 32'd1);
    chk("t3_mask",    32'(last_upd), 32'b01);
    chk("t3_digit0",  32'(bus.digit_out[3:0]), 32'h3);

    // Test 5: two anodes low
    clr_tally();
    dwell(7'($urandom_range(0, 127)), 2'b00, 8);
    chk("t5_aerr_cnt", 32'(aerr_cnt), 32'd1);
    chk("t5_upd_cnt",  32'(upd_cnt),  32'd0);
    chk("t5_dout",     32'(bus.digit_out),   32'hF3);
    chk("t5_valid",    32'(bus.digit_valid), 32'b11);

    // Test 6: reset in the middle of tracking, then a fresh capture
    clr_tally();
    dwell(7'h19, 2'b01, 3);
    chk("t6_no_early", 32'(upd_cnt), 32'd0);
    apply_reset("t6_rst");
    clr_tally();
    repeat (10) step();
    chk("t6_upd_cnt", 32'(upd_cnt),  32'd1);
    chk("t6_upd_cyc", 32'(upd_last), 32'(S + 3));
    chk("t6_dout",    32'(bus.digit_out),   32'h40);
    chk("t6_valid",   32'(bus.digit_valid), 32'b10);

    // Sweep every table code on every digit
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < 16; i++) begin
        dwell(codes[i], ~(ND'(1) << k), 8);
        chk("sweep_val",   32'(bus.digit_out[4*k +: 4]), 32'(i));
        chk("sweep_valid", 32'(bus.digit_valid[k]),      32'd1);
      end
    end

    // Randomized dwells, including short glitches and bad anode patterns
    for (int d = 0; d < 250; d++) begin
      logic [6:0]    rs;
      logic [ND-1:0] ra;
      int            sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = '1;
      else if (sel == 1) ra = '0;
      else               ra = ~(ND'(1) << $urandom_range(0, ND - 1));
      sel = $urandom_range(0, 17);
      if (sel < 16)       rs = codes[sel];
      else if (sel == 16) rs = 7'h7F;
      else                rs = 7'($urandom_range(0, 127));
      dwell(rs, ra, $urandom_range(1, 10));
      if (d == 125) apply_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
